bus_cycle_ctrl: RTL and testbench



---
 rtl/bus_cycle_ctrl.sv | 164 ++++++++++++++++
 tb/tb_bus_cycle_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_ctrl.sv
// 8085 external bus cycle controller: address demux, strobe decode, wait states, read-data return.
// Optional BUS_TIMEOUT_EN adds a ready-low watchdog that forces completion and flags bus_err.
module bus_cycle_ctrl #(
  parameter int MEM_WAIT    = 0,
  parameter int IO_WAIT     = 1,
  parameter int WAIT_W      = 3,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic        clk,
  input  logic        resetn_in,
  input  logic        ale,
  input  logic [7:0]  ad_in,
  input  logic [7:0]  haddress,
  input  logic        s0,
  input  logic        s1,
  input  logic        iomn,
  input  logic        rdn,
  input  logic        wrn,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_rdy,
  output logic [15:0] addr,
  output logic [7:0]  wdata,
  output logic        memrn,
  output logic        memwn,
  output logic        iorn,
  output logic        iown,
  output logic        ready,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  output logic [1:0]  cyc_status,
  output logic        bus_err
);

  if (MEM_WAIT < 0 || MEM_WAIT >= (1 << WAIT_W) || IO_WAIT < 0 || IO_WAIT >= (1 << WAIT_W))
  begin : g_bad_wait
    $error("bus_cycle_ctrl: wait-state parameter does not fit in WAIT_W bits");
  end

  localparam logic [WAIT_W-1:0] MEM_WAIT_L = WAIT_W'(MEM_WAIT);
  localparam logic [WAIT_W-1:0] IO_WAIT_L  = WAIT_W'(IO_WAIT);

  typedef enum logic [1:0] {IDLE, ADDR, ACTIVE, HOLD} state_t;
  state_t state, state_nxt;

  logic              io_q, wr_q, rd_done;
  logic [WAIT_W-1:0] wcnt;
  logic              ready_raw, to_fired, to_fire;

  wire both_lo   = !rdn && !wrn;
  wire both_hi   =  rdn &&  wrn;
  wire ale_lat   = ale && (state != HOLD);
  wire enter_act = (state == ADDR) && !ale && !both_lo && !both_hi;
  wire cap_ok    = (state == ACTIVE) && !ale && !wr_q && !rd_done &&
                   (wcnt == '0) && ext_rdy;

  assign ready_raw = !((state == ACTIVE) && ((wcnt != '0) || !ext_rdy));

  // state register
  always_ff @(posedge clk or negedge resetn_in)
    if (!resetn_in) state <= IDLE;
    else            state <= state_nxt;

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (ale) state_nxt = ADDR;
      ADDR:   if (ale)           state_nxt = ADDR;
              else if (both_lo)  state_nxt = HOLD;
              else if (!both_hi) state_nxt = ACTIVE;
      ACTIVE: if (ale)           state_nxt = ADDR;
              else if (both_hi)  state_nxt = IDLE;
      HOLD:   if (both_hi)       state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // outputs: strobes follow the registered state, so they move only on clock edges or reset
  always_comb begin
    memrn = 1'b1;
    memwn = 1'b1;
    iorn  = 1'b1;
    iown  = 1'b1;
    ad_oe = 1'b0;
    ready = ready_raw || to_fired;
    if (state == ACTIVE) begin
      if (io_q) begin
        iorn = wr_q;
        iown = !wr_q;
      end else begin
        memrn = wr_q;
        memwn = !wr_q;
      end
      ad_oe = !wr_q;
    end
  end

  always_ff @(posedge clk or negedge resetn_in) begin
    if (!resetn_in) begin
      addr       <= '0;
      cyc_status <= '0;
      io_q       <= 1'b0;
      wr_q       <= 1'b0;
      rd_done    <= 1'b0;
      wcnt       <= '0;
      wdata      <= '0;
      ad_out     <= '0;
      bus_err    <= 1'b0;
    end else begin
      if (ale_lat) begin
        addr       <= {haddress, ad_in};
        cyc_status <= {s1, s0};
        io_q       <= iomn;
        wcnt       <= iomn ? IO_WAIT_L : MEM_WAIT_L;
      end else if (state == ACTIVE && wcnt != '0) begin
        wcnt <= wcnt - 1'b1;
      end
      if (enter_act) begin
        wr_q    <= !wrn;
        rd_done <= 1'b0;
        if (!wrn) wdata <= ad_in;
      end
      if (state == ADDR && !ale && both_lo) bus_err <= 1'b1;
      if (cap_ok) begin
        ad_out  <= ext_rdata;
        rd_done <= 1'b1;
      end
      if (to_fire) begin
        bus_err <= 1'b1;
        if (!wr_q) begin
          ad_out  <= 8'hFF;
          rd_done <= 1'b1;
        end
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  assign to_fire = (state == ACTIVE) && !ale && !ready_raw && !to_fired &&
                   (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // counts consecutive ready-low cycles of the current ACTIVE cycle
  always_ff @(posedge clk or negedge resetn_in) begin
    if (!resetn_in) begin
      to_cnt   <= '0;
      to_fired <= 1'b0;
    end else if (state != ACTIVE || ale) begin
      to_cnt   <= '0;
      to_fired <= 1'b0;
    end else if (to_fire) begin
      to_fired <= 1'b1;
    end else if (!ready_raw && !to_fired) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign to_fired = 1'b0;
  assign to_fire  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl with an expected-value queue for latched address/data.
module tb_bus_cycle_ctrl;
  logic        clk = 1'b0;
  logic        resetn_in;
  logic        ale, s0, s1, iomn, rdn, wrn, ext_rdy;
  logic [7:0]  ad_in, haddress, ext_rdata;
  logic [15:0] addr;
  logic [7:0]  wdata, ad_out;
  logic        memrn, memwn, iorn, iown, ready, ad_oe, bus_err;
  logic [1:0]  cyc_status;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  bus_cycle_ctrl dut (
    .clk(clk), .resetn_in(resetn_in), .ale(ale), .ad_in(ad_in), .haddress(haddress),
    .s0(s0), .s1(s1), .iomn(iomn), .rdn(rdn), .wrn(wrn), .ext_rdata(ext_rdata),
    .ext_rdy(ext_rdy), .addr(addr), .wdata(wdata), .memrn(memrn), .memwn(memwn),
    .iorn(iorn), .iown(iown), .ready(ready), .ad_out(ad_out), .ad_oe(ad_oe),
    .cyc_status(cyc_status), .bus_err(bus_err)
  );

  wire [3:0] strb = {memrn, memwn, iorn, iown};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_chk(input string tag, input logic [15:0] obs);
    if (sb_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s: got %h expected <none queued>", tag, obs);
    end else begin
      chk(tag, obs, sb_q.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cyc(input logic [15:0] a, input logic io, input logic [1:0] st);
    ale = 1'b1; haddress = a[15:8]; ad_in = a[7:0]; iomn = io; {s1, s0} = st;
    sb_q.push_back(a);
    sb_q.push_back({14'd0, st});
  endtask

  initial begin
    int n;
    resetn_in = 1'b0; ale = 0; s0 = 0; s1 = 0; iomn = 0; rdn = 1; wrn = 1;
    ext_rdy = 1; ad_in = 0; haddress = 0; ext_rdata = 0;
    #23;
    chk("rst_addr", addr, 16'h0000);
    chk("rst_strb", {12'd0, strb}, 16'h000F);
    chk("rst_ready", {15'd0, ready}, 16'h1);
    chk("rst_oe_err", {14'd0, ad_oe, bus_err}, 16'h0);
    chk("rst_misc", {wdata, ad_out}, 16'h0000);
    chk("rst_status", {14'd0, cyc_status}, 16'h0);
    resetn_in = 1'b1;
    step();

    // zero-wait memory read
    start_cyc(16'h1234, 1'b0, 2'b10);
    step();
    sb_chk("mr_addr", addr);
    sb_chk("mr_status", {14'd0, cyc_status});
    chk("mr_strb_addr", {12'd0, strb}, 16'h000F);
    ale = 0; rdn = 0; ext_rdata = 8'hA5; sb_q.push_back(16'h00A5);
    step();
    chk("mr_strb_act", {12'd0, strb}, 16'h0007);
    chk("mr_ready", {15'd0, ready}, 16'h1);
    chk("mr_oe", {15'd0, ad_oe}, 16'h1);
    step();
    sb_chk("mr_ad_out", {8'd0, ad_out});
    chk("mr_strb_act2", {12'd0, strb}, 16'h0007);
    chk("mr_ready2", {15'd0, ready}, 16'h1);
    rdn = 1;
    step();
    chk("mr_strb_end", {12'd0, strb}, 16'h000F);
    chk("mr_oe_end", {15'd0, ad_oe}, 16'h0);

    // IO write with one wait state
    start_cyc(16'h0080, 1'b1, 2'b01);
    step();
    sb_chk("iw_addr", addr);
    sb_chk("iw_status", {14'd0, cyc_status});
    ale = 0; wrn = 0; ad_in = 8'h5A; sb_q.push_back(16'h005A);
    step();
    chk("iw_strb", {12'd0, strb}, 16'h000E);
    chk("iw_ready_wait", {15'd0, ready}, 16'h0);
    sb_chk("iw_wdata", {8'd0, wdata});
    chk("iw_oe", {15'd0, ad_oe}, 16'h0);
    step();
    chk("iw_ready_done", {15'd0, ready}, 16'h1);
    chk("iw_strb2", {12'd0, strb}, 16'h000E);
    wrn = 1;
    step();
    chk("iw_strb_end", {12'd0, strb}, 16'h000F);

    // memory read stretched by ext_rdy
    start_cyc(16'h4000, 1'b0, 2'b10);
    step();
    sb_chk("st_addr", addr);
    sb_chk("st_status", {14'd0, cyc_status});
    ale = 0; rdn = 0; ext_rdy = 0; ext_rdata = 8'hC3;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("st_ready_low", {15'd0, ready}, 16'h0);
      chk("st_ad_hold", {8'd0, ad_out}, 16'h00A5);
      step();
    end
    ext_rdy = 1; sb_q.push_back(16'h00C3);
    #1;
    chk("st_ready_back", {15'd0, ready}, 16'h1);
    chk("st_ad_pre", {8'd0, ad_out}, 16'h00A5);
    step();
    sb_chk("st_ad_out", {8'd0, ad_out});
    ext_rdata = 8'h11;
    step();
    chk("st_ad_keep", {8'd0, ad_out}, 16'h00C3);
    rdn = 1;
    step();
    chk("st_strb_end", {12'd0, strb}, 16'h000F);

    // both strobes low: protocol error
    start_cyc(16'h2000, 1'b0, 2'b11);
    step();
    sb_chk("pe_addr", addr);
    sb_chk("pe_status", {14'd0, cyc_status});
    ale = 0; rdn = 0; wrn = 0;
    step();
    chk("pe_err", {15'd0, bus_err}, 16'h1);
    chk("pe_strb", {12'd0, strb}, 16'h000F);
    chk("pe_oe", {15'd0, ad_oe}, 16'h0);
    step();
    chk("pe_strb_hold", {12'd0, strb}, 16'h000F);
    rdn = 1; wrn = 1;
    step();
    start_cyc(16'h3000, 1'b0, 2'b01);
    step();
    sb_chk("pe_next_addr", addr);
    sb_chk("pe_next_status", {14'd0, cyc_status});
    ale = 0; wrn = 0; ad_in = 8'h77; sb_q.push_back(16'h0077);
    step();
    chk("pe_next_strb", {12'd0, strb}, 16'h000B);
    chk("pe_next_ready", {15'd0, ready}, 16'h1);
    sb_chk("pe_next_wdata", {8'd0, wdata});
    chk("pe_err_sticky", {15'd0, bus_err}, 16'h1);
    wrn = 1;
    step();

    // async reset in the middle of an IO write
    start_cyc(16'h0081, 1'b1, 2'b01);
    step();
    sb_chk("ar_addr", addr);
    sb_chk("ar_status", {14'd0, cyc_status});
    ale = 0; wrn = 0; ad_in = 8'h99;
    step();
    chk("ar_iown_pre", {15'd0, iown}, 16'h0);
    chk("ar_ready_pre", {15'd0, ready}, 16'h0);
    #2;
    resetn_in = 0;
    #1;
    chk("ar_iown", {15'd0, iown}, 16'h1);
    chk("ar_ready", {15'd0, ready}, 16'h1);
    chk("ar_addr0", addr, 16'h0000);
    chk("ar_err0", {15'd0, bus_err}, 16'h0);
    wrn = 1;
    step();
    resetn_in = 1;
    step();

`ifdef BUS_TIMEOUT_EN
    start_cyc(16'h5555, 1'b0, 2'b10);
    step();
    sb_chk("to_addr", addr);
    sb_chk("to_status", {14'd0, cyc_status});
    ale = 0; rdn = 0; ext_rdy = 0; ext_rdata = 8'h3C;
    step();
    n = 0;
    while (ready == 1'b0 && n < 40) begin
      n++;
      step();
    end
    chk("to_low_cycles", 16'(n), 16'd15);
    chk("to_err", {15'd0, bus_err}, 16'h1);
    chk("to_ad_out", {8'd0, ad_out}, 16'h00FF);
    rdn = 1; ext_rdy = 1;
    step();
    chk("to_strb_end", {12'd0, strb}, 16'h000F);
`endif

    chk("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
